// File: rtl/stack_control.sv
// Game-sequencing FSM for the block stacker: runs the plot/delay/erase/move loop,
// latches the stop key, locks rows, evaluates overlap and ends in WIN or LOSE.
module stack_control #(
  parameter int               CNT_W      = 26,
  parameter logic [CNT_W-1:0] BASE_DELAY = 26'd12_500_000,
  parameter logic [CNT_W-1:0] DELAY_STEP = 26'd1_000_000,
  parameter logic [CNT_W-1:0] MIN_DELAY  = 26'd2_000_000,
  parameter int               NUM_ROWS   = 8,
  parameter int               ROW_W      = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             go,
  input  logic             stop,
  input  logic             done_plot,
  input  logic             overlap_ok,
  output logic             writeEn,
  output logic             colour_erase_enable,
  output logic             count_x_enable,
  output logic             reset_plot,
  output logic             ld_x,
  output logic             lock_row,
  output logic             new_row,
  output logic             clear_board,
  output logic [ROW_W-1:0] row_idx,
  output logic [CNT_W-1:0] delay_value,
  output logic             game_win,
  output logic             game_lose,
  output logic [3:0]       state_code
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WAIT_REL = 4'd1,
    START    = 4'd2,
    PLOT     = 4'd3,
    RELOAD   = 4'd4,
    DELAY    = 4'd5,
    CHECK    = 4'd6,
    ERASE    = 4'd7,
    UPDATE   = 4'd8,
    LOCK     = 4'd9,
    EVAL     = 4'd10,
    NEXT_ROW = 4'd11,
    WIN      = 4'd12,
    LOSE     = 4'd13
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] delay_reg;
  logic [ROW_W-1:0] row_reg;
  logic             stop_lat_reg;
  logic             stop_window;
  logic             last_row;
  logic [CNT_W:0]   delay_diff;
  logic [CNT_W-1:0] delay_sat;

  // One extra bit catches underflow before the floor is applied.
  assign delay_diff = {1'b0, delay_reg} - {1'b0, DELAY_STEP};
  assign delay_sat  = (delay_diff[CNT_W] || (delay_diff[CNT_W-1:0] < MIN_DELAY))
                      ? MIN_DELAY : delay_diff[CNT_W-1:0];
  assign last_row   = (row_reg == ROW_W'(NUM_ROWS - 1));

  always_comb begin
    stop_window = 1'b0;
    case (state_reg)
      PLOT, RELOAD, DELAY, CHECK, ERASE, UPDATE: stop_window = 1'b1;
      default:                                   stop_window = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      delay_reg    <= BASE_DELAY;
      row_reg      <= '0;
      stop_lat_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == START || state_reg == LOCK) begin
        stop_lat_reg <= 1'b0;
      end else if (stop_window && stop) begin
        stop_lat_reg <= 1'b1;
      end
      if (state_reg == RELOAD) begin
        cnt_reg <= delay_reg;
      end else if (state_reg == DELAY && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
      if (state_reg == START) begin
        row_reg   <= '0;
        delay_reg <= BASE_DELAY;
      end else if (state_reg == NEXT_ROW) begin
        row_reg   <= row_reg + 1'b1;
        delay_reg <= delay_sat;
      end
    end
  end

  always_comb begin
    state_next          = IDLE;
    writeEn             = 1'b0;
    colour_erase_enable = 1'b0;
    count_x_enable      = 1'b0;
    reset_plot          = 1'b0;
    ld_x                = 1'b0;
    lock_row            = 1'b0;
    new_row             = 1'b0;
    clear_board         = 1'b0;
    game_win            = 1'b0;
    game_lose           = 1'b0;
    case (state_reg)
      IDLE: begin
        reset_plot = 1'b1;
        state_next = go ? WAIT_REL : IDLE;
      end
      WAIT_REL: state_next = go ? WAIT_REL : START;
      START: begin
        clear_board = 1'b1;
        reset_plot  = 1'b1;
        state_next  = PLOT;
      end
      PLOT: begin
        writeEn        = 1'b1;
        count_x_enable = 1'b1;
        state_next     = done_plot ? RELOAD : PLOT;
      end
      RELOAD: begin
        reset_plot = 1'b1;
        state_next = DELAY;
      end
      DELAY: state_next = (cnt_reg == '0) ? CHECK : DELAY;
      CHECK: state_next = stop_lat_reg ? LOCK : ERASE;
      ERASE: begin
        writeEn             = 1'b1;
        count_x_enable      = 1'b1;
        colour_erase_enable = 1'b1;
        state_next          = done_plot ? UPDATE : ERASE;
      end
      UPDATE: begin
        ld_x       = 1'b1;
        reset_plot = 1'b1;
        state_next = PLOT;
      end
      LOCK: begin
        lock_row   = 1'b1;
        state_next = EVAL;
      end
      EVAL: begin
        if (!overlap_ok)   state_next = LOSE;
        else if (last_row) state_next = WIN;
        else               state_next = NEXT_ROW;
      end
      NEXT_ROW: begin
        new_row    = 1'b1;
        reset_plot = 1'b1;
        state_next = PLOT;
      end
      WIN: begin
        game_win   = 1'b1;
        state_next = go ? WAIT_REL : WIN;
      end
      LOSE: begin
        game_lose  = 1'b1;
        state_next = go ? WAIT_REL : LOSE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign row_idx     = row_reg;
  assign delay_value = delay_reg;
  assign state_code  = state_reg;

endmodule
